// File: rtl/ifetch_ctrl_pkg.sv
// Shared fetch/decode pipeline definitions: data width, the bubble instruction,
// and the fetch FSM state encoding.
package ifetch_ctrl_pkg;

  localparam int XLEN = 32;

  // RV32I "addi x0, x0, 0"
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_ctrl_if_id_reg.sv
// Fetch-to-decode register bank. Priority: flush, load, hold, otherwise bubble
// (bubble clears valid and instr but keeps the PCs).
module if_id_reg
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            load,
  input  logic            hold,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc4_d,
  output logic            valid_d
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_d <= NOP_INSTR;
      pc_d    <= '0;
      pc4_d   <= '0;
      valid_d <= 1'b0;
    end else if (flush) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (load) begin
      instr_d <= load_instr;
      pc_d    <= load_pc;
      pc4_d   <= load_pc + XLEN'(4);
      valid_d <= 1'b1;
    end else if (!hold) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: single-outstanding request FSM, fetch PC,
// one-entry response hold buffer and redirect handling.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_REQ     | request driven at pc_f, waiting for grant
// ST_WAIT    | granted, waiting for the response
// ST_HOLD    | response captured in hold_buf while decode is stalled
// ST_DISCARD | redirected with a response in flight; drop the next rvalid
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_e,
  input  logic [XLEN-1:0] redirect_pc_e,
  input  logic            stall_d,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc4_d,
  output logic            valid_d
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc_f, pc_f_next;
  logic [XLEN-1:0] req_pc, req_pc_next;
  logic [XLEN-1:0] hold_buf, hold_buf_next;
  logic [XLEN-1:0] req_pc4;
  logic            dec_load;
  logic [XLEN-1:0] dec_instr;

  assign req_pc4 = req_pc + XLEN'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_REQ;
      pc_f     <= RESET_PC;
      req_pc   <= '0;
      hold_buf <= '0;
    end else begin
      state    <= state_next;
      pc_f     <= pc_f_next;
      req_pc   <= req_pc_next;
      hold_buf <= hold_buf_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_f_next     = pc_f;
    req_pc_next   = req_pc;
    hold_buf_next = hold_buf;
    dec_load      = 1'b0;
    dec_instr     = imem_rdata;

    case (state)
      ST_REQ: begin
        if (redirect_e) begin
          state_next = imem_gnt ? ST_DISCARD : ST_REQ;
        end else if (imem_gnt) begin
          req_pc_next = pc_f;
          state_next  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_e) begin
          state_next = imem_rvalid ? ST_REQ : ST_DISCARD;
        end else if (imem_rvalid) begin
          if (stall_d) begin
            hold_buf_next = imem_rdata;
            state_next    = ST_HOLD;
          end else begin
            dec_load   = 1'b1;
            pc_f_next  = req_pc4;
            state_next = ST_REQ;
          end
        end
      end
      ST_HOLD: begin
        if (redirect_e) begin
          state_next = ST_REQ;
        end else if (!stall_d) begin
          dec_load   = 1'b1;
          dec_instr  = hold_buf;
          pc_f_next  = req_pc4;
          state_next = ST_REQ;
        end
      end
      ST_DISCARD: begin
        // a redirect here only retargets pc_f; the in-flight response must still drain
        if (imem_rvalid) state_next = ST_REQ;
      end
      default: state_next = ST_REQ;
    endcase

    if (redirect_e) pc_f_next = word_align(redirect_pc_e);
  end

  // gated by rst so the request drops combinationally while reset is held
  assign imem_req  = (state == ST_REQ) && !rst;
  assign imem_addr = pc_f;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_e),
    .load      (dec_load),
    .hold      (stall_d),
    .load_instr(dec_instr),
    .load_pc   (req_pc),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pc4_d     (pc4_d),
    .valid_d   (valid_d)
  );

endmodule
